// File: rtl/exec_pkg.sv
// Shared execution-cluster types: completion-slot state encoding and default widths.
package exec_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_BUSY = 2'd1,
        SLOT_DONE = 2'd2
    } slot_state_e;

    localparam int DEF_NUM_FU     = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ROB_W      = 4;
    localparam int DEF_DEST_W     = 3;
    localparam int DEF_CTRL_W     = 6;
    localparam int DEF_LAT_W      = 4;

endpackage

// File: rtl/fu_slot.sv
// One functional-unit completion slot: IDLE/BUSY/DONE FSM, latency counter and
// the payload (tags plus captured result) that it presents for writeback.
module fu_slot
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROB_W      = DEF_ROB_W,
    parameter int DEST_W     = DEF_DEST_W,
    parameter int CTRL_W     = DEF_CTRL_W,
    parameter int LAT_W      = DEF_LAT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  load,
    input  logic                  retire,
    input  logic [LAT_W-1:0]      latency,
    input  logic [ROB_W-1:0]      issue_rob,
    input  logic [DEST_W-1:0]     issue_dest,
    input  logic [CTRL_W-1:0]     issue_ctrl,
    input  logic [DATA_WIDTH-1:0] result,
    output slot_state_e           state,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ROB_W-1:0]      rob,
    output logic [DEST_W-1:0]     dest,
    output logic [CTRL_W-1:0]     ctrl
);

    slot_state_e           state_r;
    logic [LAT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [ROB_W-1:0]      rob_r;
    logic [DEST_W-1:0]     dest_r;
    logic [CTRL_W-1:0]     ctrl_r;

    // A zero latency behaves exactly like a single-cycle operation.
    function automatic logic [LAT_W-1:0] load_count(input logic [LAT_W-1:0] lat);
        load_count = (lat == '0) ? LAT_W'(1) : lat;
    endfunction

    // Slot FSM: count down while BUSY, capture the unit result on the last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= SLOT_IDLE;
            cnt_r   <= '0;
            data_r  <= '0;
            rob_r   <= '0;
            dest_r  <= '0;
            ctrl_r  <= '0;
        end else if (flush) begin
            state_r <= SLOT_IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                SLOT_IDLE: begin
                    if (load) begin
                        state_r <= SLOT_BUSY;
                        cnt_r   <= load_count(latency);
                        rob_r   <= issue_rob;
                        dest_r  <= issue_dest;
                        ctrl_r  <= issue_ctrl;
                    end
                end
                SLOT_BUSY: begin
                    if (cnt_r == LAT_W'(1)) begin
                        state_r <= SLOT_DONE;
                        cnt_r   <= '0;
                        data_r  <= result;
                    end else begin
                        cnt_r <= cnt_r - LAT_W'(1);
                    end
                end
                SLOT_DONE: begin
                    if (retire) begin
                        state_r <= SLOT_IDLE;
                    end
                end
                default: begin
                    state_r <= SLOT_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign state = state_r;
    assign data  = data_r;
    assign rob   = rob_r;
    assign dest  = dest_r;
    assign ctrl  = ctrl_r;

endmodule

// File: rtl/fu_completion_arbiter.sv
// Completion arbiter: NUM_FU latency-tracking slots sharing one writeback port.
// Define FU_COMPLETION_RR_EN for round-robin grant; the default is fixed priority.
module fu_completion_arbiter
    import exec_pkg::*;
#(
    parameter int  NUM_FU     = DEF_NUM_FU,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  ROB_W      = DEF_ROB_W,
    parameter int  DEST_W     = DEF_DEST_W,
    parameter int  CTRL_W     = DEF_CTRL_W,
    parameter int  LAT_W      = DEF_LAT_W,
    localparam int FU_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [FU_W-1:0]              issue_fu,
    input  logic [LAT_W-1:0]             issue_latency,
    input  logic [ROB_W-1:0]             issue_rob,
    input  logic [DEST_W-1:0]            issue_dest,
    input  logic [CTRL_W-1:0]            issue_ctrl,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
    output logic [NUM_FU-1:0]            fu_free,
    output logic                         issue_err,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [DATA_WIDTH-1:0]        wb_data,
    output logic [ROB_W-1:0]             wb_rob,
    output logic [DEST_W-1:0]            wb_dest,
    output logic [CTRL_W-1:0]            wb_ctrl,
    output logic [FU_W-1:0]              wb_fu
);

    slot_state_e           state_s [NUM_FU];
    logic [DATA_WIDTH-1:0] data_s  [NUM_FU];
    logic [ROB_W-1:0]      rob_s   [NUM_FU];
    logic [DEST_W-1:0]     dest_s  [NUM_FU];
    logic [CTRL_W-1:0]     ctrl_s  [NUM_FU];
    logic [NUM_FU-1:0]     done_s;
    logic [NUM_FU-1:0]     load_s;
    logic [NUM_FU-1:0]     retire_s;

    logic                  fu_in_range_s;
    logic                  issue_ok_s;
    logic                  handshake_s;
    logic [FU_W-1:0]       arb_idx_s;
    logic [FU_W-1:0]       grant_s;
    logic                  hold_valid_r;
    logic [FU_W-1:0]       hold_idx_r;
    logic                  issue_err_r;

    assign fu_in_range_s = ({1'b0, issue_fu} < (FU_W + 1)'(NUM_FU));
    assign issue_ok_s    = issue_valid && fu_in_range_s && fu_free[issue_fu];
    assign wb_valid      = |done_s;
    assign handshake_s   = wb_valid && wb_ready && !flush;
    // A stalled grant stays locked so later completions cannot disturb wb_*.
    assign grant_s       = hold_valid_r ? hold_idx_r : arb_idx_s;
    assign issue_err     = issue_err_r;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
        assign load_s[g]   = issue_ok_s && !flush && (issue_fu == FU_W'(g));
        assign retire_s[g] = handshake_s && (grant_s == FU_W'(g));
        assign done_s[g]   = (state_s[g] == SLOT_DONE);
        assign fu_free[g]  = (state_s[g] == SLOT_IDLE);

        fu_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROB_W      (ROB_W),
            .DEST_W     (DEST_W),
            .CTRL_W     (CTRL_W),
            .LAT_W      (LAT_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .load       (load_s[g]),
            .retire     (retire_s[g]),
            .latency    (issue_latency),
            .issue_rob  (issue_rob),
            .issue_dest (issue_dest),
            .issue_ctrl (issue_ctrl),
            .result     (fu_result[g*DATA_WIDTH +: DATA_WIDTH]),
            .state      (state_s[g]),
            .data       (data_s[g]),
            .rob        (rob_s[g]),
            .dest       (dest_s[g]),
            .ctrl       (ctrl_s[g])
        );
    end

`ifdef FU_COMPLETION_RR_EN
    logic [FU_W-1:0] ptr_r;
    logic [FU_W-1:0] low_idx_s;
    logic [FU_W-1:0] after_idx_s;
    logic            after_found_s;

    // Round-robin pick: first DONE slot above the last grant, else wrap to lowest.
    always_comb begin
        low_idx_s     = '0;
        after_idx_s   = '0;
        after_found_s = 1'b0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            low_idx_s     = done_s[i] ? FU_W'(i) : low_idx_s;
            after_idx_s   = (done_s[i] && (FU_W'(i) > ptr_r)) ? FU_W'(i) : after_idx_s;
            after_found_s = after_found_s | (done_s[i] && (FU_W'(i) > ptr_r));
        end
        arb_idx_s = after_found_s ? after_idx_s : low_idx_s;
    end

    // Last-granted pointer moves only when a writeback actually completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (handshake_s) begin
            ptr_r <= grant_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: lowest-index DONE slot wins.
    always_comb begin
        arb_idx_s = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            arb_idx_s = done_s[i] ? FU_W'(i) : arb_idx_s;
        end
    end
`endif

    // Grant lock held across back-pressure cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_r <= 1'b0;
            hold_idx_r   <= '0;
        end else if (flush || handshake_s) begin
            hold_valid_r <= 1'b0;
            hold_idx_r   <= '0;
        end else if (wb_valid) begin
            hold_valid_r <= 1'b1;
            hold_idx_r   <= grant_s;
        end else begin
            hold_valid_r <= 1'b0;
            hold_idx_r   <= '0;
        end
    end

    // Dropped-issue flag, one cycle after the offending request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_err_r <= 1'b0;
        end else if (flush) begin
            issue_err_r <= 1'b0;
        end else begin
            issue_err_r <= issue_valid && !issue_ok_s;
        end
    end

    // Writeback payload mux; all fields read as zero when nothing is DONE.
    always_comb begin
        wb_data = '0;
        wb_rob  = '0;
        wb_dest = '0;
        wb_ctrl = '0;
        wb_fu   = '0;
        if (wb_valid) begin
            wb_data = data_s[grant_s];
            wb_rob  = rob_s[grant_s];
            wb_dest = dest_s[grant_s];
            wb_ctrl = ctrl_s[grant_s];
            wb_fu   = grant_s;
        end else begin
            wb_fu   = '0;
        end
    end

endmodule

// File: tb/tb_fu_completion_arbiter.sv
// Scoreboard bench for fu_completion_arbiter: a timestamp-based slot model predicts
// each writeback; a negedge monitor pops and compares every handshake.
module tb_fu_completion_arbiter;

    localparam int NUM_FU     = 5;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_W      = 4;
    localparam int DEST_W     = 3;
    localparam int CTRL_W     = 6;
    localparam int LAT_W      = 4;
    localparam int FU_W       = 3;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         flush;
    logic                         issue_valid;
    logic [FU_W-1:0]              issue_fu;
    logic [LAT_W-1:0]             issue_latency;
    logic [ROB_W-1:0]             issue_rob;
    logic [DEST_W-1:0]            issue_dest;
    logic [CTRL_W-1:0]            issue_ctrl;
    logic [NUM_FU*DATA_WIDTH-1:0] fu_result;
    logic [NUM_FU-1:0]            fu_free;
    logic                         issue_err;
    logic                         wb_valid;
    logic                         wb_ready;
    logic [DATA_WIDTH-1:0]        wb_data;
    logic [ROB_W-1:0]             wb_rob;
    logic [DEST_W-1:0]            wb_dest;
    logic [CTRL_W-1:0]            wb_ctrl;
    logic [FU_W-1:0]              wb_fu;

    always #5 clk = ~clk;

    fu_completion_arbiter #(
        .NUM_FU(NUM_FU), .DATA_WIDTH(DATA_WIDTH), .ROB_W(ROB_W),
        .DEST_W(DEST_W), .CTRL_W(CTRL_W), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
        .issue_fu(issue_fu), .issue_latency(issue_latency), .issue_rob(issue_rob),
        .issue_dest(issue_dest), .issue_ctrl(issue_ctrl), .fu_result(fu_result),
        .fu_free(fu_free), .issue_err(issue_err), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_data(wb_data), .wb_rob(wb_rob), .wb_dest(wb_dest),
        .wb_ctrl(wb_ctrl), .wb_fu(wb_fu)
    );

    typedef struct packed {
        logic [FU_W-1:0]       fu;
        logic [DATA_WIDTH-1:0] data;
        logic [ROB_W-1:0]      rob;
        logic [DEST_W-1:0]     dest;
        logic [CTRL_W-1:0]     ctrl;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  checks = 0;
    int  passed = 0;

    // Model: each slot is idle (0), executing until edge m_due (1), or finished (2).
    int  m_phase [NUM_FU];
    int  m_due   [NUM_FU];
    wb_t m_res   [NUM_FU];
    int  m_presented;
    int  m_last;
    bit  m_err;
    int  cyc = 0;
    logic [DATA_WIDTH-1:0] res_v [NUM_FU];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            m_phase[i] = 0;
            m_due[i]   = 0;
            m_res[i]   = '0;
        end
        m_presented = -1;
        m_last      = 0;
        m_err       = 1'b0;
    endtask

    function automatic int pick();
        int start;
`ifdef FU_COMPLETION_RR_EN
        start = m_last + 1;
`else
        start = 0;
`endif
        for (int k = 0; k < NUM_FU; k++)
            if (m_phase[(start + k) % NUM_FU] == 2) return (start + k) % NUM_FU;
        return -1;
    endfunction

    // Predict what the coming clock edge does, given the inputs now driven.
    task automatic model_edge(input bit iv, input int fu, input int lat, input int rob,
                              input int dest, input int ctrl, input bit rdy, input bit fl);
        int  edge_n;
        int  g;
        bit  ok;
        edge_n = cyc + 1;
        if (fl) begin
            for (int i = 0; i < NUM_FU; i++) m_phase[i] = 0;
            m_err = 1'b0;
            m_presented = -1;
            return;
        end
        ok    = iv && (fu < NUM_FU) && (m_phase[fu] == 0);
        m_err = iv && !ok;
        g = (m_presented >= 0) ? m_presented : pick();
        if (g >= 0) begin
            if (rdy) begin
                exp_q.push_back(m_res[g]);
                m_phase[g]  = 0;
                m_presented = -1;
                m_last      = g;
            end else begin
                m_presented = g;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (m_phase[i] == 1 && m_due[i] == edge_n) begin
                m_phase[i]    = 2;
                m_res[i].data = res_v[i];
            end
        end
        if (ok) begin
            m_phase[fu]    = 1;
            m_due[fu]      = edge_n + ((lat == 0) ? 1 : lat);
            m_res[fu].fu   = FU_W'(fu);
            m_res[fu].rob  = ROB_W'(rob);
            m_res[fu].dest = DEST_W'(dest);
            m_res[fu].ctrl = CTRL_W'(ctrl);
        end
    endtask

    // One clock: drive, predict, advance, then compare registered outputs.
    task automatic step(input bit iv, input int fu, input int lat, input int rob,
                        input int dest, input int ctrl, input bit rdy, input bit fl);
        logic [NUM_FU-1:0] exp_free;
        bit any_done;
        issue_valid   = iv;
        issue_fu      = FU_W'(fu);
        issue_latency = LAT_W'(lat);
        issue_rob     = ROB_W'(rob);
        issue_dest    = DEST_W'(dest);
        issue_ctrl    = CTRL_W'(ctrl);
        wb_ready      = rdy;
        flush         = fl;
        for (int i = 0; i < NUM_FU; i++) begin
            res_v[i] = $urandom;
            fu_result[i*DATA_WIDTH +: DATA_WIDTH] = res_v[i];
        end
        model_edge(iv, fu, lat, rob, dest, ctrl, rdy, fl);
        @(posedge clk);
        cyc++;
        #1;
        any_done = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            exp_free[i] = (m_phase[i] == 0);
            if (m_phase[i] == 2) any_done = 1'b1;
        end
        check("fu_free", 64'(fu_free), 64'(exp_free));
        check("issue_err", 64'(issue_err), 64'(m_err));
        check("wb_valid", 64'(wb_valid), 64'(any_done));
        if (m_presented >= 0) check("held_wb_fu", 64'(wb_fu), 64'(m_presented));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, rdy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fu_free"}, 64'(fu_free), 64'({NUM_FU{1'b1}}));
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'(0));
        check({tag, "_issue_err"}, 64'(issue_err), 64'(0));
        check({tag, "_wb_fields"}, 64'({wb_fu, wb_data, wb_rob, wb_dest, wb_ctrl}), 64'(0));
    endtask

    // Monitor: every DUT handshake must match the next predicted writeback.
    always @(negedge clk) begin
        if (!reset && wb_valid && wb_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL wb_unexpected: got fu=%0d data=%0h expected no writeback", wb_fu, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_payload", 64'({wb_fu, wb_data, wb_rob, wb_dest, wb_ctrl}), 64'(mon_e));
            end
        end else if (!wb_valid) begin
            check("wb_zero", 64'({wb_fu, wb_data, wb_rob, wb_dest, wb_ctrl}), 64'(0));
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_fu = '0;
        issue_latency = '0; issue_rob = '0; issue_dest = '0; issue_ctrl = '0;
        fu_result = '0; wb_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // slot 2, latency 3, rob 5
        step(1'b1, 2, 3, 5, 1, 9, 1'b1, 1'b0);
        idle(5, 1'b1);
        // latency 0 behaves as latency 1
        step(1'b1, 0, 0, 3, 2, 4, 1'b1, 1'b0);
        idle(3, 1'b1);
        // drops: busy slot 1, out-of-range slot 7
        step(1'b1, 1, 6, 1, 1, 1, 1'b1, 1'b0);
        step(1'b1, 1, 2, 2, 2, 2, 1'b1, 1'b0);
        step(1'b1, 7, 1, 0, 0, 0, 1'b1, 1'b0);
        idle(8, 1'b1);
        // slots 0, 1, 3 finish on the same edge
        step(1'b1, 0, 3, 10, 0, 10, 1'b1, 1'b0);
        step(1'b1, 1, 2, 11, 1, 11, 1'b1, 1'b0);
        step(1'b1, 3, 1, 12, 3, 12, 1'b1, 1'b0);
        idle(6, 1'b1);
        // back-pressure on slot 4, plus a later completion during the stall
        step(1'b1, 4, 2, 7, 4, 33, 1'b0, 1'b0);
        step(1'b1, 0, 3, 8, 5, 34, 1'b0, 1'b0);
        idle(6, 1'b0);
        idle(4, 1'b1);
        // flush with slot 1 busy and slot 2 done
        step(1'b1, 1, 10, 1, 1, 1, 1'b0, 1'b0);
        step(1'b1, 2, 1, 2, 2, 2, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 3, 1, 3, 3, 3, 1'b1, 1'b1);
        idle(12, 1'b1);
        // asynchronous reset pulse between edges, same situation
        step(1'b1, 1, 10, 1, 1, 1, 1'b0, 1'b0);
        step(1'b1, 2, 1, 2, 2, 2, 1'b0, 1'b0);
        idle(3, 1'b0);
        #1 reset = 1'b1;
        #1 check_reset_state("async_reset");
        reset = 1'b0;
        model_reset();
        idle(12, 1'b1);

        for (int n = 0; n < 500; n++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end
        idle(25, 1'b1);
        check("drain_queue", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
